// File: rtl/color_seq_monitor.sv
// RGB LED colour monitor: synchronizes and debounces the three drive pins, reports
// each accepted colour with its dwell time, and checks that colours advance in order.
module color_seq_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int DWELL_W       = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               red_in,
    input  logic               green_in,
    input  logic               blue_in,
    output logic [2:0]         color,
    output logic               color_valid,
    output logic [DWELL_W-1:0] dwell,
    output logic               seq_error,
    output logic               invalid_color,
    output logic               locked,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_TRACK1   = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_DONE  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         r_stable;
    logic [2:0]         r_cand;
    logic [CNT_W-1:0]   r_cnt;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [2:0]         r_ref;
    state_t             r_state;

    logic [2:0] w_sample;
    logic       w_accept;
    logic [2:0] w_code;
    logic [2:0] w_next_ref;
    logic       w_in_order;

    function automatic logic [2:0] rgb_to_code(input logic [2:0] rgb);
        case (rgb)
            3'b100:  return 3'd0;
            3'b110:  return 3'd1;
            3'b010:  return 3'd2;
            3'b011:  return 3'd3;
            3'b001:  return 3'd4;
            3'b101:  return 3'd5;
            3'b000:  return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    assign w_sample    = r_sync2;
    assign w_accept    = (r_cnt == CNT_DONE);
    assign w_code      = rgb_to_code(r_cand);
    assign w_next_ref  = (r_ref == 3'd5) ? 3'd0 : r_ref + 3'd1;
    assign w_in_order  = (w_code == w_next_ref);
    assign o_dbg_state = r_state;

    // Stability filter; on an accept the same-cycle sample may already start the next candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_cand   <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= {red_in, green_in, blue_in};
            r_sync2 <= r_sync1;
            if (w_accept) begin
                r_stable <= r_cand;
                if (w_sample == r_cand) begin
                    r_cnt <= '0;
                end else begin
                    r_cand <= w_sample;
                    r_cnt  <= CNT_ONE;
                end
            end else if (w_sample == r_stable) begin
                r_cand <= r_stable;
                r_cnt  <= '0;
            end else if ((r_cnt != '0) && (w_sample == r_cand)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cand <= w_sample;
                r_cnt  <= CNT_ONE;
            end
        end
    end

    // Order tracker and registered outputs; every pulse is tied to an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_UNLOCKED;
            r_ref         <= 3'd0;
            r_dwell_cnt   <= '0;
            color         <= 3'd6;
            color_valid   <= 1'b0;
            dwell         <= '0;
            seq_error     <= 1'b0;
            invalid_color <= 1'b0;
            locked        <= 1'b0;
        end else begin
            color_valid   <= w_accept;
            seq_error     <= 1'b0;
            invalid_color <= 1'b0;
            if (w_accept) begin
                r_dwell_cnt <= DWELL_ONE;
                dwell       <= r_dwell_cnt;
                color       <= w_code;
                if (w_code[2:1] == 2'b11) begin
                    invalid_color <= 1'b1;
                    r_state       <= ST_UNLOCKED;
                    locked        <= 1'b0;
                end else begin
                    r_ref <= w_code;
                    case (r_state)
                        ST_UNLOCKED: begin
                            r_state <= ST_TRACK1;
                            locked  <= 1'b0;
                        end
                        ST_TRACK1: begin
                            if (w_in_order) begin
                                r_state <= ST_LOCKED;
                                locked  <= 1'b1;
                            end
                        end
                        ST_LOCKED: begin
                            if (!w_in_order) begin
                                seq_error <= 1'b1;
                                r_state   <= ST_TRACK1;
                                locked    <= 1'b0;
                            end
                        end
                        default: begin
                            r_state <= ST_UNLOCKED;
                            locked  <= 1'b0;
                        end
                    endcase
                end
            end else if (r_dwell_cnt != DWELL_MAX) begin
                r_dwell_cnt <= r_dwell_cnt + DWELL_ONE;
            end
        end
    end

endmodule

// File: tb/tb_color_seq_monitor.sv
// Bench for color_seq_monitor: directed scenarios plus random colour streams, checked
// every cycle against a run-length based reference model and an accept scoreboard.
module tb_color_seq_monitor;

    localparam int S = 4;
    localparam logic [2:0] C_R = 3'b100, C_Y = 3'b110, C_G = 3'b010, C_C = 3'b011;
    localparam logic [2:0] C_B = 3'b001, C_M = 3'b101, C_OFF = 3'b000, C_W = 3'b111;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;
    logic red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;

    logic [2:0]  a_color, b_color;
    logic        a_valid, b_valid, a_seq, b_seq, a_inv, b_inv, a_locked, b_locked;
    logic [23:0] a_dwell;
    logic [7:0]  b_dwell;
    logic [1:0]  a_state, b_state;

    color_seq_monitor #(.STABLE_CYCLES(S), .DWELL_W(24)) dut_a (
        .clk(clk), .rst(rst), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .color(a_color), .color_valid(a_valid), .dwell(a_dwell), .seq_error(a_seq),
        .invalid_color(a_inv), .locked(a_locked), .o_dbg_state(a_state)
    );

    color_seq_monitor #(.STABLE_CYCLES(S), .DWELL_W(8)) dut_b (
        .clk(clk), .rst(rst), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .color(b_color), .color_valid(b_valid), .dwell(b_dwell), .seq_error(b_seq),
        .invalid_color(b_inv), .locked(b_locked), .o_dbg_state(b_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference model: acceptance from run lengths of the sampled pin vector
    logic [2:0] m_pin_d1 = '0, m_pin_d2 = '0, m_run_val = '0, m_stable = '0;
    int  m_run_len = 0, m_since = 0;
    int  m_color = 6, m_dwell_a = 0, m_dwell_b = 0, m_ref = 0;
    bit  m_valid = 0, m_seq = 0, m_inv = 0, m_locked = 0, m_have_ref = 0;
    logic [2:0] exp_q[$];

    function automatic int code_of(input logic [2:0] rgb);
        case (rgb)
            C_R:     return 0;
            C_Y:     return 1;
            C_G:     return 2;
            C_C:     return 3;
            C_B:     return 4;
            C_M:     return 5;
            C_OFF:   return 6;
            default: return 7;
        endcase
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        int c;
        if (rst) begin
            m_pin_d1 = '0; m_pin_d2 = '0; m_run_val = '0; m_run_len = 0; m_stable = '0;
            m_since = 0; m_color = 6; m_dwell_a = 0; m_dwell_b = 0;
            m_valid = 0; m_seq = 0; m_inv = 0; m_locked = 0; m_have_ref = 0;
        end else begin
            m_valid = 0; m_seq = 0; m_inv = 0;
            if (m_run_len == S && m_run_val != m_stable) begin
                c = code_of(m_run_val);
                m_stable  = m_run_val;
                m_color   = c;
                m_valid   = 1;
                m_dwell_a = min_i(m_since, 32'hFF_FFFF);
                m_dwell_b = min_i(m_since, 255);
                m_since   = 1;
                exp_q.push_back(3'(c));
                if (c >= 6) begin
                    m_inv = 1; m_have_ref = 0; m_locked = 0;
                end else if (!m_have_ref) begin
                    m_have_ref = 1; m_ref = c;
                end else begin
                    if (c == (m_ref + 1) % 6) m_locked = 1;
                    else begin
                        m_seq = m_locked;
                        m_locked = 0;
                    end
                    m_ref = c;
                end
            end else begin
                m_since++;
            end
            if (m_pin_d2 == m_run_val) m_run_len = min_i(m_run_len + 1, S + 1);
            else begin
                m_run_val = m_pin_d2;
                m_run_len = 1;
            end
            m_pin_d2 = m_pin_d1;
            m_pin_d1 = {red_in, green_in, blue_in};
        end
    endtask

    // per-cycle comparison and scoreboard
    int cyc = 0, n_valid = 0, n_seq = 0, n_inv = 0, last_valid_cyc = -1;
    int last_dwell_a = 0, last_dwell_b = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            check("a_color", 32'(a_color), 32'(m_color));
            check("a_valid", 32'(a_valid), 32'(m_valid));
            check("a_dwell", 32'(a_dwell), 32'(m_dwell_a));
            check("a_seq_error", 32'(a_seq), 32'(m_seq));
            check("a_invalid", 32'(a_inv), 32'(m_inv));
            check("a_locked", 32'(a_locked), 32'(m_locked));
            check("b_valid", 32'(b_valid), 32'(m_valid));
            check("b_dwell", 32'(b_dwell), 32'(m_dwell_b));
            check("b_locked", 32'(b_locked), 32'(m_locked));
            if (a_valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
                last_dwell_a = 32'(a_dwell);
                last_dwell_b = 32'(b_dwell);
                if (exp_q.size() == 0) check("sb_extra_accept", 32'(a_valid), 32'd0);
                else check("sb_color", 32'(a_color), 32'(exp_q.pop_front()));
            end
            if (a_seq === 1'b1) n_seq++;
            if (a_inv === 1'b1) n_inv++;
        end
    end

    // driver tasks
    task automatic drive(input logic [2:0] v, input int n);
        @(negedge clk);
        {red_in, green_in, blue_in} = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [2:0] rgb_of [8];
    logic [2:0] seq7 [7];

    initial begin
        int v0, s0, i0, set_cyc, cur, r, hold;
        rgb_of = '{C_R, C_Y, C_G, C_C, C_B, C_M, C_OFF, C_W};
        seq7   = '{C_R, C_Y, C_G, C_C, C_B, C_M, C_R};
        do_reset(3);
        check("reset_color", 32'(a_color), 32'd6);
        check("reset_dwell", 32'(a_dwell), 32'd0);

        // first accept latency after reset
        @(negedge clk);
        set_cyc = cyc;
        {red_in, green_in, blue_in} = C_R;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("first_latency", 32'(last_valid_cyc - set_cyc - 1), 32'd6);
        check("first_color", 32'(a_color), 32'd0);
        check("first_locked", 32'(a_locked), 32'd0);
        check("first_no_err", 32'(n_seq + n_inv), 32'd0);

        // full in-order cycle
        drive(C_OFF, 0);
        do_reset(2);
        v0 = n_valid; s0 = n_seq;
        for (int i = 0; i < 7; i++) drive(seq7[i], 100);
        check("cycle_pulses", 32'(n_valid - v0), 32'd7);
        check("cycle_dwell", 32'(last_dwell_a), 32'd100);
        check("cycle_locked", 32'(a_locked), 32'd1);
        check("cycle_no_seq", 32'(n_seq - s0), 32'd0);

        // short blue glitch while locked on green
        drive(C_Y, 100);
        drive(C_G, 100);
        v0 = n_valid;
        drive(C_C, 3);
        drive(C_G, 60);
        check("glitch_no_pulse", 32'(n_valid - v0), 32'd0);
        drive(C_C, 50);
        check("glitch_dwell", 32'(last_dwell_a), 32'd163);
        check("cyan_locked", 32'(a_locked), 32'd1);

        // out-of-order colour, then relock
        s0 = n_seq;
        drive(C_R, 50);
        check("ooo_seq_pulse", 32'(n_seq - s0), 32'd1);
        check("ooo_unlocked", 32'(a_locked), 32'd0);
        drive(C_Y, 50);
        check("relock", 32'(a_locked), 32'd1);

        // invalid colours and dwell saturation
        i0 = n_inv;
        drive(C_OFF, 50);
        check("off_color", 32'(a_color), 32'd6);
        check("off_pulse", 32'(n_inv - i0), 32'd1);
        check("off_unlocked", 32'(a_locked), 32'd0);
        drive(C_W, 50);
        check("white_color", 32'(a_color), 32'd7);
        check("white_pulse", 32'(n_inv - i0), 32'd2);
        drive(C_R, 300);
        drive(C_Y, 50);
        check("dwell_sat8", 32'(last_dwell_b), 32'd255);
        check("dwell_wide", 32'(last_dwell_a), 32'd300);

        // reset in the middle of a filter
        v0 = n_valid;
        drive(C_B, 2);
        do_reset(1);
        check("midrst_color", 32'(a_color), 32'd6);
        check("midrst_locked", 32'(a_locked), 32'd0);
        check("midrst_dwell", 32'(a_dwell), 32'd0);
        check("midrst_no_pulse", 32'(n_valid - v0), 32'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midrst_accept", 32'(n_valid - v0), 32'd1);
        check("midrst_color2", 32'(a_color), 32'd4);

        // random colour streams with glitches and occasional resets
        cur = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
            r = $urandom_range(0, 9);
            if (r < 6 && cur < 6) cur = (cur + 1) % 6;
            else if (r < 6) cur = $urandom_range(0, 5);
            else cur = $urandom_range(0, 7);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 15);
            drive(rgb_of[cur], hold);
        end

        repeat (20) @(posedge clk);
        @(negedge clk);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/color_seq_monitor.md
COLOR_SEQ_MONITOR -- requirements
Module: color_seq_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, giving the number of consecutive identical samples (>=1) before a new RGB value is accepted.
REQ-002 SHALL have parameter DWELL_W, default 24, giving the dwell counter width (covers 2,000,000-cycle intervals).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports red_in, green_in and blue_in, each an input, 1 bit: asynchronous RGB LED drive levels being monitored.
REQ-006 SHALL have port color, output, 3 bits: the accepted colour code. RED=0, YELLOW=1, GREEN=2, CYAN=3, BLUE=4, MAGENTA=5, OFF=6 (rgb 000), WHITE=7 (rgb 111).
REQ-007 SHALL have port color_valid, output, 1 bit: one-cycle pulse on each accepted colour change.
REQ-008 SHALL have port dwell, output, DWELL_W bits: cycles between this accept and the previous accept; updated only when color_valid is high.
REQ-009 SHALL have port seq_error, output, 1 bit: one-cycle pulse when an out-of-order colour is accepted while locked.
REQ-010 SHALL have port invalid_color, output, 1 bit: one-cycle pulse when OFF or WHITE is accepted.
REQ-011 SHALL have port locked, output, 1 bit: a level signal, high while the FSM is in LOCKED.

Function
REQ-012 SHALL pass each RGB input through a two-flop synchronizer; the sampled vector is the synchronizer output.
REQ-013 SHALL keep the stable vector, a candidate vector and a stability counter.
REQ-014 SHALL clear the counter and discard the candidate when the sample equals the stable vector.
REQ-015 SHALL load a differing sample as the new candidate with count 1.
REQ-016 SHALL increment the count while the sample keeps equalling the candidate.
REQ-017 SHALL accept the candidate when the count reaches STABLE_CYCLES.
REQ-018 SHALL assert color_valid exactly STABLE_CYCLES+2 cycles after the first clk edge that captures a new pin value held steady; color updates in the same cycle.
REQ-019 SHALL produce no pulse when the input glitches for fewer than STABLE_CYCLES sampled cycles.
REQ-020 SHALL restart the filter with the new candidate when the input changes to a third value mid-filter.
REQ-021 SHALL run a dwell counter: set to 1 on an accept, otherwise incremented, saturating at 2^DWELL_W-1.
REQ-022 SHALL on accept latch dwell from the counter's pre-update value, so accepts at cycles a and b give dwell=b-a.
REQ-023 SHALL report the saturated value in dwell when the counter is saturated at an accept.
REQ-024 SHALL define next(c) for codes 0-5 as (c+1) mod 6, and SHALL track order with FSM states UNLOCKED, TRACK1 and LOCKED plus a 3-bit ref register.
REQ-025 SHALL in UNLOCKED, on an accepted code 0-5, set ref to the code and go to TRACK1.
REQ-026 SHALL in TRACK1, on an accepted code equal to next(ref), go to LOCKED; otherwise stay in TRACK1; ref is updated and seq_error stays low in both cases.
REQ-027 SHALL in LOCKED, on an accepted code equal to next(ref), stay in LOCKED; otherwise pulse seq_error and go to TRACK1; ref is updated in both cases.
REQ-028 SHALL in any state, on accepting OFF or WHITE, pulse invalid_color and go to UNLOCKED, with no seq_error.
REQ-029 SHALL assert seq_error and invalid_color only in the same cycle as color_valid, never in other cycles.

Reset
REQ-030 SHALL while rst is high on a clk edge clear the synchronizers, the stable vector, the candidate, the stability counter and the dwell counter to 0.
REQ-031 SHALL while rst is high on a clk edge set color=6 (OFF), clear color_valid, seq_error, invalid_color and locked to 0, and set dwell=0.
REQ-032 SHALL while rst is high on a clk edge set the FSM to UNLOCKED.
REQ-033 SHALL give rst priority over every same-cycle event.
REQ-034 SHALL abandon any in-progress filter on reset without producing a pulse.
REQ-035 SHALL after reset accept rgb=000 silently, since it equals the reset stable vector.

Verification (STABLE_CYCLES=4 unless stated)
REQ-036 SHALL verify: reset, then red_in=1 at edge 0 -> color_valid at edge 6, color=0, locked=0, no error pulses.
REQ-037 SHALL verify: R,Y,G,C,B,M,R each held 100 cycles -> seven color_valid pulses, dwell=100 from the second onward, locked=1 from the YELLOW accept, seq_error never asserted.
REQ-038 SHALL verify: while locked on GREEN, blue_in high for 3 cycles -> no color_valid and the dwell count is undisturbed.
REQ-039 SHALL verify: while locked on CYAN, drive RED -> color_valid, seq_error pulse, locked=0; then YELLOW -> locked=1.
REQ-040 SHALL verify: drive 000, then 111, while locked -> invalid_color pulses with color=6 then color=7, locked=0; with DWELL_W=8, hold RED 300 cycles -> dwell=255.
REQ-041 SHALL verify: rst pulsed 2 cycles into a filter -> no color_valid, outputs at reset values, then a normal accept follows.
